// File: rtl/pc_npc_unit.sv
// Program counter and next-PC selection for the single-cycle MIPS fetch path.
// PC is registered; NPC and PC4 are combinational from the current PC and controls.
module pc_npc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic [25:0] imm,
    input  logic [31:0] A,
    input  logic [1:0]  PC_op,
    input  logic        zero,
    output logic [31:0] PC,
    output logic [31:0] NPC,
    output logic [31:0] PC4
);

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        OP_SEQ  = 2'b00,
        OP_BEQ  = 2'b01,
        OP_JUMP = 2'b10,
        OP_JR   = 2'b11
    } pc_op_e;

    logic [ADDR_W-1:0] branch_offset;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;

    // Current instruction address; reset wins over the clock.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            PC <= RESET_PC;
        end else begin
            PC <= NPC;
        end
    end

    assign PC4           = PC + ADDR_W'(PC_STEP);
    assign branch_offset = {{14{imm[15]}}, imm[15:0], 2'b00};
    assign branch_target = PC4 + branch_offset;
    // Upper nibble comes from the current PC, not PC+4.
    assign jump_target   = {PC[31:28], imm, 2'b00};

    always_comb begin
        NPC = PC4;
        unique case (pc_op_e'(PC_op))
            OP_SEQ:  NPC = PC4;
            OP_BEQ:  NPC = zero ? branch_target : PC4;
            OP_JUMP: NPC = jump_target;
            OP_JR:   NPC = A;
            default: NPC = PC4;
        endcase
    end

endmodule

// File: tb/tb_pc_npc_unit.sv
// Directed self-checking bench for pc_npc_unit: reset, sequential fetch, beq, j, jr,
// asynchronous mid-run reset and 32-bit wrap of PC+4.
module tb_pc_npc_unit;

    logic        clk;
    logic        res;
    logic [25:0] imm;
    logic [31:0] A;
    logic [1:0]  PC_op;
    logic        zero;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic [31:0] PC4;

    int n_cmp = 0;
    int n_err = 0;

    pc_npc_unit dut (
        .clk   (clk),
        .res   (res),
        .imm   (imm),
        .A     (A),
        .PC_op (PC_op),
        .zero  (zero),
        .PC    (PC),
        .NPC   (NPC),
        .PC4   (PC4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and sample away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load an arbitrary PC through jr.
    task automatic load_pc(input logic [31:0] target);
        PC_op = 2'b11;
        A     = target;
        tick();
    endtask

    initial begin
        res   = 1'b1;
        imm   = '0;
        A     = '0;
        PC_op = 2'b00;
        zero  = 1'b0;

        // 1. Reset and sequential fetch
        tick();
        tick();
        check("reset_pc",  PC,  32'h0000_3000);
        check("reset_pc4", PC4, 32'h0000_3004);
        check("reset_npc", NPC, 32'h0000_3004);
        @(negedge clk);
        res = 1'b0;
        #1;
        check("release_hold", PC, 32'h0000_3000);
        tick();
        check("seq1_pc",  PC,  32'h0000_3004);
        check("seq1_pc4", PC4, 32'h0000_3008);
        tick();
        check("seq2_pc",  PC,  32'h0000_3008);
        tick();
        check("seq3_pc",  PC,  32'h0000_300C);
        check("seq3_pc4", PC4, 32'h0000_3010);
        tick();
        check("seq4_pc",  PC,  32'h0000_3010);

        // 2. Branches from 0x3010
        PC_op = 2'b01;
        imm   = 26'h000_0003;
        zero  = 1'b1;
        #1;
        check("beq_taken_npc", NPC, 32'h0000_3020);
        zero = 1'b0;
        #1;
        check("beq_not_taken_npc", NPC, 32'h0000_3014);
        zero = 1'b1;
        tick();
        check("beq_taken_pc", PC, 32'h0000_3020);
        load_pc(32'h0000_3010);
        check("jr_to_3010", PC, 32'h0000_3010);
        PC_op = 2'b01;
        imm   = 26'h000_FFFE;
        zero  = 1'b1;
        #1;
        check("beq_back_npc", NPC, 32'h0000_300C);
        // Upper imm bits must not leak into the branch offset
        imm = 26'h3FF_0003;
        #1;
        check("beq_imm_hi_ignored", NPC, 32'h0000_3020);
        PC_op = 2'b00;
        #1;
        check("seq_zero_ignored", NPC, 32'h0000_3014);

        // 3. Jump
        load_pc(32'h0000_3000);
        PC_op = 2'b10;
        imm   = 26'h000_0C05;
        zero  = 1'b1;
        #1;
        check("j_low_npc", NPC, 32'h0000_3014);
        load_pc(32'hA000_0000);
        PC_op = 2'b10;
        imm   = 26'h000_0C05;
        zero  = 1'b0;
        #1;
        check("j_high_npc", NPC, 32'hA000_3014);
        tick();
        check("j_high_pc", PC, 32'hA000_3014);
        load_pc(32'hF000_0000);
        PC_op = 2'b10;
        imm   = 26'h3FF_FFFF;
        #1;
        check("j_full_imm_npc", NPC, 32'hFFFF_FFFC);

        // 4. Jump register
        PC_op = 2'b11;
        A     = 32'h0000_3100;
        zero  = 1'b1;
        #1;
        check("jr_npc", NPC, 32'h0000_3100);
        tick();
        check("jr_pc", PC, 32'h0000_3100);
        A = 32'h0000_3102;
        tick();
        check("jr_unaligned_pc", PC, 32'h0000_3102);

        // 5. Asynchronous reset mid-run
        load_pc(32'h0000_3040);
        check("pre_async_pc", PC, 32'h0000_3040);
        PC_op = 2'b00;
        @(negedge clk);
        #2;
        res = 1'b1;
        #1;
        check("async_reset_pc",  PC,  32'h0000_3000);
        check("async_reset_npc", NPC, 32'h0000_3004);
        #1;
        res = 1'b0;
        tick();
        check("after_async_pc", PC, 32'h0000_3004);

        // 6. Wrap-around
        load_pc(32'hFFFF_FFFC);
        PC_op = 2'b00;
        #1;
        check("wrap_pc4", PC4, 32'h0000_0000);
        check("wrap_npc", NPC, 32'h0000_0000);
        tick();
        check("wrap_pc", PC, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_npc_unit.md
Name: pc_npc_unit

Overview:
- Program-counter register plus next-PC logic for the single-cycle MIPS fetch path.
- Holds the current instruction address and computes the next address each cycle from the PC control code, the 26-bit instruction immediate field, register operand A and the ALU zero flag.
- Its PC output addresses instruction memory (memory index = (PC − 0x3000)[13:2]) in the fetch unit.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; start of the text segment.
- PC_STEP, 4, byte increment for sequential fetch.

Ports:
- clk  input  1  system clock; PC updates on the rising edge.
- res  input  1  reset, asynchronous, active-high; forces PC to RESET_PC.
- imm  input  26  instruction bits [25:0]; the low 16 bits are the branch offset, all 26 bits are the jump target index.
- A  input  32  register value used as the jr target.
- PC_op  input  2  next-PC select code.
- zero  input  1  branch condition from ALU compare (1 = equal).
- PC  output  32  current PC.
- NPC  output  32  next PC (combinational).
- PC4  output  32  PC + 4 (combinational; link value for jal).

Behaviour:
- The clock is clk. Reset is res, asynchronous and active-high.
- PC register:
  - On posedge res, or whenever res is high, PC = RESET_PC (0x0000_3000), independent of clk.
  - Otherwise, on each posedge clk, PC <= NPC.
  - Single-cycle loop: the new PC is visible one clock after NPC is computed.
  - When res is deasserted, PC holds 0x3000 until the next rising edge.
- PC4 = PC + 4, modulo 2^32 (0xFFFF_FFFC + 4 wraps to 0x0000_0000).
- NPC is purely combinational from PC, PC_op, imm, A and zero:
  - PC_op = 2'b00, sequential: NPC = PC + 4.
  - PC_op = 2'b01, beq: if zero = 1, NPC = PC + 4 + (sign_extend(imm[15:0]) << 2); if zero = 0, NPC = PC + 4. All arithmetic is 32-bit and wraps modulo 2^32.
  - PC_op = 2'b10, j/jal: NPC = {PC[31:28], imm[25:0], 2'b00}. The upper nibble comes from PC, not PC + 4.
  - PC_op = 2'b11, jr: NPC = A, passed through unmodified. No alignment check; misaligned A is loaded as is.
- zero is ignored for every PC_op other than 2'b01.
- No X propagation from an unused select: every PC_op value produces a defined NPC.
- There is no stall or enable input; PC advances every cycle when not in reset.
- Reset asserted mid-operation: PC goes to 0x3000 immediately (asynchronously). NPC and PC4 then follow combinationally from 0x3000.

Test Plan:
1. Reset and sequential fetch: assert res, then release with PC_op = 00.
   - PC = 0x3000 during reset.
   - After 3 rising edges: 0x3004, 0x3008, 0x300C.
   - PC4 always equals PC + 4.
2. Branches: PC = 0x3010, PC_op = 01.
   - imm[15:0] = 0x0003, zero = 1 → NPC = 0x3020; next PC = 0x3020.
   - Same inputs with zero = 0 → NPC = 0x3014.
   - imm[15:0] = 0xFFFE, zero = 1 → NPC = 0x300C (backward branch).
3. Jump: PC = 0x3000, PC_op = 10, imm = 26'h0000C05 → NPC = 0x0000_3014.
   - With PC = 0xA000_0000 and the same imm → NPC = 0xA000_3014.
4. Jump register: PC_op = 11, A = 0x0000_3100 → NPC = 0x3100; PC = 0x3100 after the edge.
   - A = 0x0000_3102 → PC = 0x3102, loaded unaligned.
5. Asynchronous reset mid-run: while PC = 0x3040, pulse res between clock edges.
   - PC = 0x3000 immediately, before any clock edge.
   - After release with PC_op = 00, the next edge gives 0x3004.
6. Wrap-around: force PC to 0xFFFF_FFFC via jr, then PC_op = 00.
   - PC4 = 0x0000_0000; next PC = 0x0000_0000.
